// File: rtl/ss_pkt_arb_pkg.sv
// Shared types and a software-style round-robin helper for the packet arbiter.
// The helper mirrors the hardware pick rule so checkers can compute grants directly.
package ss_pkt_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int MAX_IN = 16;

    // First requester strictly after last_idx, wrapping modulo num_in; last_idx if none.
    function automatic logic [3:0] rr_pick(input logic [MAX_IN-1:0] req,
                                           input logic [3:0]        last_idx,
                                           input int                num_in);
        logic [3:0] pick;
        logic [3:0] cand;
        pick = last_idx;
        cand = '0;
        for (int k = MAX_IN; k >= 1; k--) begin
            if (k <= num_in) begin
                cand = 4'((int'(last_idx) + k) % num_in);
                if (req[cand]) begin
                    pick = cand;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/ss_rr_pick.sv
// Combinational rotating priority encoder: finds the first set request
// strictly after last_idx, wrapping around modulo NUM_IN.
module ss_rr_pick
    import ss_pkt_arb_pkg::*;
#(
    parameter int  NUM_IN = 4,
    localparam int IDX_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req_i,
    input  logic [IDX_W-1:0]  last_idx_i,
    output logic              any_o,
    output logic [IDX_W-1:0]  pick_o
);

    logic [IDX_W-1:0] cand;

    // Walk from the farthest candidate back to the nearest so the nearest wins.
    always_comb begin
        any_o  = 1'b0;
        pick_o = last_idx_i;
        cand   = '0;
        for (int k = NUM_IN; k >= 1; k--) begin
            cand = IDX_W'((int'(last_idx_i) + k) % NUM_IN);
            if (req_i[cand]) begin
                any_o  = 1'b1;
                pick_o = cand;
            end
        end
    end

endmodule

// File: rtl/ss_pkt_arb.sv
// Packet-level round-robin arbiter: NUM_IN ss streams share one registered
// output stream; a granted input owns the output until its last beat is taken.
module ss_pkt_arb
    import ss_pkt_arb_pkg::*;
#(
    parameter int  NUM_IN    = 4,
    parameter int  NUM_BYTES = 8,
    parameter int  USER_BITS = 2,
    localparam int IDX_W     = $clog2(NUM_IN),
    localparam int DW        = NUM_BYTES * 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_IN-1:0]             s_valid,
    output logic [NUM_IN-1:0]             s_ready,
    input  logic [NUM_IN*DW-1:0]          s_data,
    input  logic [NUM_IN*NUM_BYTES-1:0]   s_keep,
    input  logic [NUM_IN-1:0]             s_last,
    input  logic [NUM_IN*USER_BITS-1:0]   s_user,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DW-1:0]                 m_data,
    output logic [NUM_BYTES-1:0]          m_keep,
    output logic                          m_last,
    output logic [USER_BITS-1:0]          m_user,
    output logic [IDX_W-1:0]              grant_idx,
    output logic                          busy
);

    // Handshake: a beat moves on a channel at a clk edge where valid && ready;
    // once m_valid is high, m_* hold until m_ready is seen.

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       grant_q, grant_d;

    logic                   m_valid_q, m_valid_d;
    logic [DW-1:0]          m_data_q, m_data_d;
    logic [NUM_BYTES-1:0]   m_keep_q, m_keep_d;
    logic                   m_last_q, m_last_d;
    logic [USER_BITS-1:0]   m_user_q, m_user_d;

    logic                   pick_any;
    logic [IDX_W-1:0]       pick_idx;
    logic                   load_en;
    logic                   accept;

    logic                   sel_valid;
    logic                   sel_last;
    logic [DW-1:0]          sel_data;
    logic [NUM_BYTES-1:0]   sel_keep;
    logic [USER_BITS-1:0]   sel_user;

    ss_rr_pick #(
        .NUM_IN (NUM_IN)
    ) u_pick (
        .req_i      (s_valid),
        .last_idx_i (grant_q),
        .any_o      (pick_any),
        .pick_o     (pick_idx)
    );

    // Route the granted input's beat toward the output register.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        sel_keep  = '0;
        sel_user  = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_q == IDX_W'(i)) begin
                sel_valid = s_valid[i];
                sel_last  = s_last[i];
                sel_data  = s_data[i*DW +: DW];
                sel_keep  = s_keep[i*NUM_BYTES +: NUM_BYTES];
                sel_user  = s_user[i*USER_BITS +: USER_BITS];
            end
        end
    end

    assign load_en = !m_valid_q || m_ready;
    assign accept  = (state_q == LOCKED) && sel_valid && load_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= IDX_W'(NUM_IN - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (accept && sel_last) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        s_ready   = '0;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_keep_d  = m_keep_q;
        m_last_d  = m_last_q;
        m_user_d  = m_user_q;
        if (state_q == LOCKED) begin
            s_ready[grant_q] = load_en;
        end
        if (accept) begin
            m_valid_d = 1'b1;
            m_data_d  = sel_data;
            m_keep_d  = sel_keep;
            m_last_d  = sel_last;
            m_user_d  = sel_user;
        end else if (load_en) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_keep_q  <= '0;
            m_last_q  <= 1'b0;
            m_user_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_keep_q  <= m_keep_d;
            m_last_q  <= m_last_d;
            m_user_q  <= m_user_d;
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_keep    = m_keep_q;
    assign m_last    = m_last_q;
    assign m_user    = m_user_q;
    assign grant_idx = grant_q;
    assign busy      = (state_q == LOCKED);

endmodule

// File: tb/tb_ss_pkt_arb.sv
// Bench for ss_pkt_arb: queue-based per-input sources, a transfer-level model
// of grants and in-flight beats, a per-input scoreboard, vectors and random traffic.
module tb_ss_pkt_arb;

    localparam int N  = 4;
    localparam int NB = 8;
    localparam int UB = 2;
    localparam int DW = NB * 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [NB-1:0] keep;
        logic          last;
        logic [UB-1:0] user;
    } beat_t;

    typedef struct {
        logic [N-1:0] req;
        logic [1:0]   exp_grant;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N-1:0]      s_valid;
    logic [N-1:0]      s_ready;
    logic [N*DW-1:0]   s_data;
    logic [N*NB-1:0]   s_keep;
    logic [N-1:0]      s_last;
    logic [N*UB-1:0]   s_user;
    logic              m_valid;
    logic              m_ready;
    logic [DW-1:0]     m_data;
    logic [NB-1:0]     m_keep;
    logic              m_last;
    logic [UB-1:0]     m_user;
    logic [1:0]        grant_idx;
    logic              busy;

    always #5 clk = ~clk;

    ss_pkt_arb #(
        .NUM_IN    (N),
        .NUM_BYTES (NB),
        .USER_BITS (UB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_keep    (s_keep),
        .s_last    (s_last),
        .s_user    (s_user),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_keep    (m_keep),
        .m_last    (m_last),
        .m_user    (m_user),
        .grant_idx (grant_idx),
        .busy      (busy)
    );

    int           n_tests = 0;
    int           n_fail  = 0;
    beat_t        src_q[N][$];
    beat_t        sb_q[N][$];
    beat_t        exp_q[$];
    logic [N-1:0] gate = '1;
    bit           mdl_locked = 1'b0;
    int           mdl_g = N - 1;
    bit           sb_en = 1'b0;
    int           out_owner = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rr_ref(input logic [N-1:0] req, input int last);
        for (int k = 1; k <= N; k++) begin
            if (req[(last + k) % N]) return (last + k) % N;
        end
        return last;
    endfunction

    function automatic int pending();
        int p;
        p = exp_q.size() + (mdl_locked ? 1 : 0);
        for (int i = 0; i < N; i++) p += src_q[i].size();
        return p;
    endfunction

    function automatic int sb_total();
        int p;
        p = 0;
        for (int i = 0; i < N; i++) p += sb_q[i].size();
        return p;
    endfunction

    task automatic push_pkt(input int i, input int len, input logic [63:0] base, input bit inc);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = inc ? base + 64'(k) : base;
            b.keep = ($urandom_range(0, 7) == 0) ? '0 : NB'($urandom);
            b.user = UB'($urandom);
            b.last = (k == len - 1);
            src_q[i].push_back(b);
            sb_q[i].push_back(b);
        end
    endtask

    task automatic clear_src();
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            sb_q[i].delete();
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() != 0 && gate[i]) begin
                s_valid[i]           = 1'b1;
                s_data[i*DW +: DW]   = src_q[i][0].data;
                s_keep[i*NB +: NB]   = src_q[i][0].keep;
                s_last[i]            = src_q[i][0].last;
                s_user[i*UB +: UB]   = src_q[i][0].user;
            end else begin
                s_valid[i]           = 1'b0;
                s_data[i*DW +: DW]   = '0;
                s_keep[i*NB +: NB]   = '0;
                s_last[i]            = 1'b0;
                s_user[i*UB +: UB]   = '0;
            end
        end
    endtask

    // One clock: drive at the falling edge, compare, advance the model, move to next falling edge.
    task automatic step();
        logic [N-1:0] sr_exp;
        beat_t        b;
        int           src;
        drive();
        #1;
        sr_exp = '0;
        if (mdl_locked && (exp_q.size() == 0 || m_ready)) sr_exp[mdl_g] = 1'b1;
        if (!rst) begin
            chk("s_ready", s_ready, sr_exp);
            chk("m_valid", m_valid, exp_q.size() != 0);
            chk("busy", busy, mdl_locked);
            chk("grant_idx", grant_idx, mdl_g);
            if (exp_q.size() != 0) begin
                chk("m_data", m_data, exp_q[0].data);
                chk("m_keep", m_keep, exp_q[0].keep);
                chk("m_last", m_last, exp_q[0].last);
                chk("m_user", m_user, exp_q[0].user);
            end
            if (sb_en && m_valid && m_ready) begin
                src = int'(m_data[63:56]);
                if (src >= N || sb_q[src].size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected: beat tagged input %0d has no pending beat", src);
                end else begin
                    b = sb_q[src].pop_front();
                    chk("sb_data", m_data, b.data);
                    chk("sb_keep", m_keep, b.keep);
                    chk("sb_last", m_last, b.last);
                    chk("sb_user", m_user, b.user);
                end
                if (out_owner >= 0) chk("no_interleave", src, out_owner);
                out_owner = m_last ? -1 : src;
            end
        end
        if (exp_q.size() != 0 && m_ready) void'(exp_q.pop_front());
        if (rst) begin
            mdl_locked = 1'b0;
            mdl_g      = N - 1;
            exp_q.delete();
            out_owner  = -1;
        end else if (mdl_locked) begin
            if (s_valid[mdl_g] && sr_exp[mdl_g]) begin
                b = src_q[mdl_g].pop_front();
                exp_q.push_back(b);
                if (b.last) mdl_locked = 1'b0;
            end
        end else if (s_valid != '0) begin
            mdl_g      = rr_ref(s_valid, mdl_g);
            mdl_locked = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        clear_src();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drain(input string name, input int bound);
        int n;
        n = 0;
        while (pending() != 0 && n < bound) begin
            step();
            n++;
        end
        chk(name, pending(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        vec_t vecs[10];
        int   order[5];
        int   gap[4];
        int   pk_done;
        int   n;
        logic [DW-1:0] h_data;
        logic [NB-1:0] h_keep;
        logic          h_last;
        logic [UB-1:0] h_user;

        // Grant sequence from reset (last grant = 3); each row carries over the previous grant.
        vecs[0] = '{4'b0001, 2'd0};
        vecs[1] = '{4'b1111, 2'd1};
        vecs[2] = '{4'b1111, 2'd2};
        vecs[3] = '{4'b0011, 2'd0};
        vecs[4] = '{4'b1000, 2'd3};
        vecs[5] = '{4'b0110, 2'd1};
        vecs[6] = '{4'b0010, 2'd1};
        vecs[7] = '{4'b1101, 2'd2};
        vecs[8] = '{4'b1011, 2'd3};
        vecs[9] = '{4'b0101, 2'd0};

        s_valid = '0;
        s_data  = '0;
        s_keep  = '0;
        s_last  = '0;
        s_user  = '0;
        m_ready = 1'b1;
        @(negedge clk);
        do_reset();

        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_keep", m_keep, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_user", m_user, 0);
        chk("rst_grant", grant_idx, 3);
        chk("rst_busy", busy, 0);
        chk("rst_s_ready", s_ready, 0);

        // Three-beat packet on input 0.
        push_pkt(0, 3, 64'd1, 1'b1);
        step();
        chk("t1_grant", grant_idx, 0);
        chk("t1_busy_on", busy, 1);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("t1_data", m_data, k);
            chk("t1_last", m_last, k == 3);
            chk("t1_busy", busy, k != 3);
        end
        step();
        chk("t1_m_valid_off", m_valid, 0);

        // Table of arbitration vectors with single-beat packets.
        do_reset();
        for (int v = 0; v < 10; v++) begin
            for (int i = 0; i < N; i++) begin
                if (vecs[v].req[i]) push_pkt(i, 1, 64'(v * 16 + i), 1'b0);
            end
            step();
            chk("tbl_grant", grant_idx, vecs[v].exp_grant);
            for (int i = 0; i < N; i++) begin
                if (i != mdl_g) begin
                    src_q[i].delete();
                    sb_q[i].delete();
                end
            end
            drain("tbl_drain", 20);
        end

        // All inputs requesting: packets leave in order 0,1,2,3,0 with one idle cycle between.
        do_reset();
        for (int i = 0; i < N; i++) push_pkt(i, 2, 64'(i), 1'b0);
        push_pkt(0, 2, 64'd0, 1'b0);
        for (int k = 0; k < 4; k++) gap[k] = 0;
        pk_done = 0;
        n = 0;
        while (pk_done < 5 && n < 100) begin
            step();
            n++;
            if (m_valid) begin
                if (m_ready && m_last) begin
                    order[pk_done] = int'(m_data[1:0]);
                    pk_done++;
                end
            end else if (pk_done >= 1 && pk_done <= 4) begin
                gap[pk_done - 1]++;
            end
        end
        chk("t2_packets", pk_done, 5);
        for (int k = 0; k < 5; k++) chk("t2_order", order[k], k % N);
        for (int k = 0; k < 4; k++) chk("t2_gap", gap[k], 1);
        drain("t2_drain", 20);

        // Requests during a locked packet wait; next grant is 3 if valid, else 1.
        for (int v = 0; v < 2; v++) begin
            do_reset();
            push_pkt(2, 4, 64'h20, 1'b1);
            step();
            push_pkt(1, 1, 64'h10, 1'b0);
            if (v == 1) push_pkt(3, 1, 64'h30, 1'b0);
            chk("t3_sready1", s_ready[1], 0);
            for (int k = 0; k < 4; k++) begin
                step();
                chk("t3_sready1", s_ready[1], 0);
            end
            step();
            chk("t3_next_grant", grant_idx, (v == 1) ? 3 : 1);
            drain("t3_drain", 30);
        end

        // Backpressure for five cycles in the middle of a packet on input 1.
        do_reset();
        sb_en = 1'b1;
        push_pkt(1, 6, {8'd1, 24'd0, 32'($urandom)}, 1'b1);
        step();
        step();
        step();
        m_ready = 1'b0;
        h_data = m_data;
        h_keep = m_keep;
        h_last = m_last;
        h_user = m_user;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t4_hold_valid", m_valid, 1);
            chk("t4_hold_data", m_data, h_data);
            chk("t4_hold_keep", m_keep, h_keep);
            chk("t4_hold_last", m_last, h_last);
            chk("t4_hold_user", m_user, h_user);
            chk("t4_sready_g", s_ready[1], 0);
        end
        m_ready = 1'b1;
        drain("t4_drain", 30);
        step();
        chk("t4_sb_left", sb_total(), 0);
        sb_en = 1'b0;

        // Reset during beat 2 of a 4-beat packet.
        do_reset();
        push_pkt(1, 4, 64'h40, 1'b1);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_m_valid", m_valid, 0);
        chk("t6_grant", grant_idx, 3);
        chk("t6_busy", busy, 0);
        clear_src();
        push_pkt(0, 1, 64'h50, 1'b0);
        push_pkt(1, 1, 64'h51, 1'b0);
        push_pkt(3, 1, 64'h53, 1'b0);
        step();
        chk("t6_first_grant", grant_idx, 0);
        drain("t6_drain", 30);

        // 200 random packets with random valid gaps and downstream stalls.
        do_reset();
        sb_en = 1'b1;
        for (int p = 0; p < 200; p++) begin
            int i;
            i = $urandom_range(0, N - 1);
            push_pkt(i, $urandom_range(1, 6), {8'(i), 24'd0, 32'($urandom)}, 1'b1);
        end
        n = 0;
        while (pending() != 0 && n < 20000) begin
            for (int i = 0; i < N; i++) gate[i] = ($urandom_range(0, 3) != 0);
            m_ready = ($urandom_range(0, 3) != 0);
            step();
            n++;
        end
        gate    = '1;
        m_ready = 1'b1;
        chk("t5_drain", pending(), 0);
        step();
        chk("t5_sb_left", sb_total(), 0);
        sb_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ss_pkt_arb.md
Name: ss_pkt_arb

Overview:
- Packet-level round-robin arbiter that shares one downstream ss stream between NUM_IN upstream ss streams.
- Once an input is granted, it owns the output until its beat with last=1 is accepted. Packets are never interleaved.
- The output side is registered, so the block can drive a long route or feed an ss_reg_slice directly.
- Sits in front of shared consumers: DMA write engine, egress MAC, debug capture.

Parameters:
- NUM_IN, 4, number of upstream streams (2..16).
- NUM_BYTES, 8, data bytes per beat; data width = NUM_BYTES*8, keep width = NUM_BYTES.
- USER_BITS, 2, sideband user width per beat.
- IDX_W, $clog2(NUM_IN), grant index width (derived; do not override).

Ports:
- clk  input  1  single clock for all logic.
- rst  input  1  synchronous, active-high reset.
- s_valid  input  NUM_IN  per-input valid.
- s_ready  output  NUM_IN  per-input ready.
- s_data  input  NUM_IN*NUM_BYTES*8  packed per-input data; input i occupies slice i.
- s_keep  input  NUM_IN*NUM_BYTES  packed per-input byte keep.
- s_last  input  NUM_IN  per-input end of packet.
- s_user  input  NUM_IN*USER_BITS  packed per-input user.
- m_valid  output  1  output valid (registered).
- m_ready  input  1  downstream ready.
- m_data  output  NUM_BYTES*8  output data (registered).
- m_keep  output  NUM_BYTES  output keep (registered).
- m_last  output  1  output last (registered).
- m_user  output  USER_BITS  output user (registered).
- grant_idx  output  IDX_W  currently/last granted input.
- busy  output  1  high while in LOCKED.

Behaviour:
- Reset, synchronous, while rst=1 at a clk edge:
  - state=IDLE, m_valid=0, m_data/m_keep/m_last/m_user=0, grant_idx=NUM_IN-1, busy=0, s_ready=0.
  - The effect is that input 0 has highest priority after reset.
- Output register:
  - load_en = !m_valid || m_ready.
  - A beat is accepted from the granted input when s_valid[g] && s_ready[g]. That beat is registered onto m_* the same edge, and m_valid<=1.
  - If load_en && no beat is accepted, then m_valid<=0.
  - While m_valid && !m_ready, all m_* hold stable (AXI-S rule).
- State IDLE:
  - All s_ready=0.
  - If any s_valid is set, pick the first set bit scanning from grant_idx+1 upward, wrapping modulo NUM_IN.
  - Next edge: grant_idx<=pick, state<=LOCKED.
  - No valid: stay in IDLE, grant_idx unchanged.
- State LOCKED:
  - s_ready[grant_idx] = load_en. All other s_ready=0.
  - Accepted beat with s_last=1: next state IDLE.
  - Otherwise remain LOCKED.
  - Granted input deasserting valid mid-packet: stay LOCKED and wait. There is no timeout and no preemption.
- Latency and throughput:
  - One arbitration cycle per packet (IDLE to LOCKED bubble).
  - Within a packet, 1 beat/cycle when m_ready=1.
  - Input-to-output latency is 1 cycle.
- Fairness: an input that just finished a packet has lowest priority for the next pick. With all inputs continuously requesting, the grant order is 0,1,2,...,NUM_IN-1,0.
- Single-beat packet (last on first beat): LOCKED lasts exactly one accepting cycle.
- Simultaneous events:
  - New requests arriving during LOCKED are ignored until return to IDLE.
  - m_ready toggling has no effect on arbitration state.
- keep=0 beats and user are passed through unmodified; no packet checking.
- Reset mid-packet:
  - The packet is truncated. The output drops valid the next cycle without last.
  - Upstream sources must also be reset; no recovery.
- grant_idx and busy are registered.

Decomposition:
- Package ss_pkt_arb_pkg holds:
  - typedef enum logic {IDLE, LOCKED} arb_state_e;
  - function rr_pick(req, last_idx) as a reference model for the bench.
- Sub-module ss_rr_pick: purely combinational rotating priority encoder.
  - Parameter NUM_IN.
  - Inputs req[NUM_IN] and last_idx[IDX_W].
  - Outputs any and pick[IDX_W].
  - The FSM and output register stay in ss_pkt_arb.

Test Plan (NUM_IN=4, NUM_BYTES=8, USER_BITS=2):
- Reset, then s_valid=4'b0001 with a 3-beat packet on input 0 (data 1,2,3; last on 3), m_ready=1 → grant_idx=0 one cycle later; m_data=1,2,3 on consecutive cycles; m_last only on 3; busy drops the cycle after beat 3 is accepted.
- All four inputs hold 2-beat packets continuously, m_ready=1 → packets emerge in input order 0,1,2,3,0. Each beat carries data=input index. Exactly one idle m_valid cycle between packets.
- Input 2 packet in flight, input 1 raises valid mid-packet → input 1 s_ready stays 0 until input 2's last is accepted. Next grant is 3 if valid, else 1.
- Backpressure: m_ready=0 for 5 cycles mid-packet → m_data/m_keep/m_last/m_user hold constant; s_ready[g]=0 while m_valid=1. There is no data loss or duplication, checked against a scoreboard per input.
- Random valid/ready with 200 random-length packets across inputs → each input's beats reappear in order and contiguously per packet, with no interleaving and keep/user bit-exact.
- rst asserted for 1 cycle during beat 2 of a 4-beat packet → m_valid=0 and grant_idx=3 the next cycle. The next request from input 0 is granted first.
